// File: rtl/mpm_port_scheduler.sv
// Packs up to PORTS single-word requests per cycle onto the LVT memory ports with rotating priority.
// Latency: grant -> registered memory access next cycle -> read data RD_LAT cycles later; req_ready is the only backpressure.
module mpm_port_scheduler #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 512,
    parameter  int PORTS  = 4,
    parameter  int REQS   = 8,
    parameter  int RD_LAT = 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int IW     = (REQS > 1) ? $clog2(REQS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQS-1:0]  req_valid,
    input  logic [REQS-1:0]  req_we,
    input  logic [AW-1:0]    req_addr  [REQS],
    input  logic [WIDTH-1:0] req_wdata [REQS],
    output logic [REQS-1:0]  req_ready,
    output logic [REQS-1:0]  rsp_valid,
    output logic [WIDTH-1:0] rsp_data  [REQS],
    output logic [AW-1:0]    mem_addr  [PORTS],
    output logic [PORTS-1:0] mem_en,
    output logic [WIDTH-1:0] mem_d     [PORTS],
    input  logic [WIDTH-1:0] mem_q     [PORTS]
);

    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    w_rr_nxt;
    logic [REQS-1:0]  w_grant;
    logic [PORTS-1:0] w_slot_vld;
    logic [PORTS-1:0] w_slot_we;
    logic [AW-1:0]    w_slot_addr [PORTS];
    logic [WIDTH-1:0] w_slot_d    [PORTS];
    logic [IW-1:0]    w_slot_idx  [PORTS];

    logic [PORTS-1:0] r_mem_en;
    logic [AW-1:0]    r_mem_addr [PORTS];
    logic [WIDTH-1:0] r_mem_d    [PORTS];
    logic [RD_LAT:0]  r_tag_vld  [PORTS];
    logic [IW-1:0]    r_tag_idx  [PORTS][RD_LAT+1];

    // Scan in rotating order; the k-th grant lands on port k. A write conflicts with any
    // granted access to its address, a read only with a granted write.
    always_comb begin
        int               cnt;
        logic             blocked;
        logic [IW-1:0]    idx;
        logic [PORTS-1:0] s_vld;
        logic [PORTS-1:0] s_we;
        logic [AW-1:0]    s_addr [PORTS];
        logic [WIDTH-1:0] s_d    [PORTS];
        logic [IW-1:0]    s_idx  [PORTS];
        cnt      = 0;
        blocked  = 1'b0;
        idx      = '0;
        s_vld    = '0;
        s_we     = '0;
        w_grant  = '0;
        w_rr_nxt = r_rr_ptr;
        for (int p = 0; p < PORTS; p++) begin
            s_addr[p] = '0;
            s_d[p]    = '0;
            s_idx[p]  = '0;
        end
        for (int i = 0; i < REQS; i++) begin
            idx     = IW'((int'(r_rr_ptr) + i) % REQS);
            blocked = (cnt >= PORTS);
            for (int p = 0; p < PORTS; p++) begin
                if (s_vld[p] && (s_addr[p] == req_addr[idx]) && (req_we[idx] || s_we[p])) begin
                    blocked = 1'b1;
                end
            end
            if (req_valid[idx] && !blocked) begin
                w_grant[idx] = 1'b1;
                for (int p = 0; p < PORTS; p++) begin
                    if (p == cnt) begin
                        s_vld[p]  = 1'b1;
                        s_we[p]   = req_we[idx];
                        s_addr[p] = req_addr[idx];
                        s_d[p]    = req_we[idx] ? req_wdata[idx] : '0;
                        s_idx[p]  = idx;
                    end
                end
                cnt      = cnt + 1;
                w_rr_nxt = IW'((int'(idx) + 1) % REQS);
            end
        end
        w_slot_vld = s_vld;
        w_slot_we  = s_we;
        for (int p = 0; p < PORTS; p++) begin
            w_slot_addr[p] = s_addr[p];
            w_slot_d[p]    = s_d[p];
            w_slot_idx[p]  = s_idx[p];
        end
    end

    // Nothing is accepted while reset is held, even though the scan keeps running.
    assign req_ready = w_grant & {REQS{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_mem_en <= '0;
            for (int p = 0; p < PORTS; p++) begin
                r_mem_addr[p] <= '0;
                r_mem_d[p]    <= '0;
                r_tag_vld[p]  <= '0;
                for (int s = 0; s <= RD_LAT; s++) begin
                    r_tag_idx[p][s] <= '0;
                end
            end
        end else begin
            r_rr_ptr <= w_rr_nxt;
            for (int p = 0; p < PORTS; p++) begin
                r_mem_en[p]        <= w_slot_vld[p] & w_slot_we[p];
                r_mem_addr[p]      <= w_slot_addr[p];
                r_mem_d[p]         <= w_slot_d[p];
                r_tag_vld[p][0]    <= w_slot_vld[p] & ~w_slot_we[p];
                r_tag_idx[p][0]    <= w_slot_idx[p];
                for (int s = 1; s <= RD_LAT; s++) begin
                    r_tag_vld[p][s] <= r_tag_vld[p][s-1];
                    r_tag_idx[p][s] <= r_tag_idx[p][s-1];
                end
            end
        end
    end

    assign mem_en = r_mem_en;
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            mem_addr[p] = r_mem_addr[p];
            mem_d[p]    = r_mem_d[p];
        end
    end

    // A requester owns at most one port per cycle, so no two ports can target the same response slot.
    always_comb begin
        rsp_valid = '0;
        for (int r = 0; r < REQS; r++) begin
            rsp_data[r] = '0;
        end
        for (int p = 0; p < PORTS; p++) begin
            for (int r = 0; r < REQS; r++) begin
                if (r_tag_vld[p][RD_LAT] && (r_tag_idx[p][RD_LAT] == IW'(r))) begin
                    rsp_valid[r] = 1'b1;
                    rsp_data[r]  = mem_q[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_mpm_port_scheduler.sv
// Bench for mpm_port_scheduler: directed scenarios with exact-cycle checks plus a response scoreboard fed at acceptance.
`timescale 1ns/1ps
module tb_mpm_port_scheduler;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 512;
    localparam int PORTS  = 4;
    localparam int REQS   = 8;
    localparam int RD_LAT = 1;
    localparam int AW     = 9;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [REQS-1:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [AW-1:0]    req_addr  [REQS];
    logic [WIDTH-1:0] req_wdata [REQS];
    logic [WIDTH-1:0] rsp_data  [REQS];
    logic [AW-1:0]    mem_addr  [PORTS];
    logic [PORTS-1:0] mem_en;
    logic [WIDTH-1:0] mem_d     [PORTS];
    logic [WIDTH-1:0] mem_q     [PORTS];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] mem    [DEPTH];
    logic [WIDTH-1:0] shadow [DEPTH];

    typedef struct {
        int               r;
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;
    exp_t sb [$];
    exp_t e;
    exp_t n;
    logic [REQS-1:0] seen;

    mpm_port_scheduler #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .REQS(REQS), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one-cycle registered read; a read sees writes committed on earlier edges.
    always @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (mem_en[p]) mem[mem_addr[p]] <= mem_d[p];
            mem_q[p] <= mem[mem_addr[p]];
        end
    end

    function automatic logic [WIDTH-1:0] init_val(int a);
        return 32'h5A00_0000 + a * 32'h0000_0101;
    endfunction

    // Scoreboard: expected read data is captured at acceptance and due exactly two cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            seen = '0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (e.cyc != cyc || !rsp_valid[e.r] || rsp_data[e.r] !== e.data) begin
                    bad++;
                    $display("FAIL rsp_r%0d: got vld=%b data=%h at cyc %0d, want data=%h at cyc %0d",
                             e.r, rsp_valid[e.r], rsp_data[e.r], cyc, e.data, e.cyc);
                end
                seen[e.r] = 1'b1;
            end
            total++;
            if ((rsp_valid & ~seen) !== '0) begin
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b, want only %b", rsp_valid, seen);
            end
            total++;
            if ((req_ready & ~req_valid) !== '0 || $countones(req_ready) > PORTS) begin
                bad++;
                $display("FAIL ready_legal: got req_ready=%b with req_valid=%b, want subset of at most %0d",
                         req_ready, req_valid, PORTS);
            end
            for (int r = 0; r < REQS; r++) begin
                if (req_valid[r] && req_ready[r] && !req_we[r]) begin
                    n.r    = r;
                    n.data = shadow[req_addr[r]];
                    n.cyc  = cyc + 1 + RD_LAT;
                    sb.push_back(n);
                end
            end
            for (int r = 0; r < REQS; r++) begin
                if (req_valid[r] && req_ready[r] && req_we[r]) shadow[req_addr[r]] = req_wdata[r];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
        for (int r = 0; r < REQS; r++) begin
            req_addr[r]  = '0;
            req_wdata[r] = '0;
        end
    endtask

    task automatic set_rd(int r, logic [AW-1:0] a);
        req_valid[r] = 1'b1;
        req_we[r]    = 1'b0;
        req_addr[r]  = a;
    endtask

    task automatic set_wr(int r, logic [AW-1:0] a, logic [WIDTH-1:0] d);
        req_valid[r] = 1'b1;
        req_we[r]    = 1'b1;
        req_addr[r]  = a;
        req_wdata[r] = d;
    endtask

    task automatic do_reset();
        idle();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [REQS-1:0] any_rsp;
        #2 rst_n = 1'b0;
        for (int r = 0; r < REQS; r++) set_rd(r, AW'(9'h080 + r));
        @(negedge clk);
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        total++; if (mem_en !== '0 || mem_addr[0] !== '0 || mem_d[0] !== '0) begin
            bad++; $display("FAIL reset_issue: got en=%b addr0=%h d0=%h want 0", mem_en, mem_addr[0], mem_d[0]); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp: got %b want 0", rsp_valid); end
        tick();
        rst_n = 1'b1;
        set_wr(0, 9'h1F0, 32'h77);
        @(negedge clk);
        total++; if (req_ready !== 8'h0F) begin bad++; $display("FAIL reset_first_grant: got %b want 00001111", req_ready); end
        tick();
        total++; if (mem_en !== 4'b0001) begin bad++; $display("FAIL pre_reset_en: got %b want 0001", mem_en); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (mem_en !== '0) begin bad++; $display("FAIL async_reset_en: got %b want 0", mem_en); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL async_reset_ready: got %b want 0", req_ready); end
        total++; if (mem_addr[1] !== '0) begin bad++; $display("FAIL async_reset_addr: got %h want 0", mem_addr[1]); end
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        any_rsp = '0;
        repeat (4) begin
            @(negedge clk);
            any_rsp = any_rsp | rsp_valid;
        end
        total++; if (any_rsp !== '0) begin bad++; $display("FAIL dropped_reads: got rsp_valid=%b want 0", any_rsp); end
        tick();
        for (int r = 0; r < REQS; r++) set_rd(r, AW'(9'h080 + r));
        @(negedge clk);
        total++; if (req_ready !== 8'h0F) begin bad++; $display("FAIL rr_after_reset: got %b want 00001111", req_ready); end
        tick();
        idle();
    endtask

    task automatic test_full_load();
        do_reset();
        for (int r = 0; r < REQS; r++) set_rd(r, AW'(9'h040 + r));
        @(negedge clk);
        total++; if (req_ready !== 8'h0F) begin bad++; $display("FAIL full_c0: got %b want 00001111", req_ready); end
        tick();
        req_valid[3:0] = '0;
        @(negedge clk);
        total++; if (req_ready !== 8'hF0) begin bad++; $display("FAIL full_c1: got %b want 11110000", req_ready); end
        total++; if (mem_en !== '0) begin bad++; $display("FAIL full_en: got %b want 0", mem_en); end
        for (int k = 0; k < PORTS; k++) begin
            total++; if (mem_addr[k] !== AW'(9'h040 + k)) begin
                bad++; $display("FAIL full_port%0d_c0: got %h want %h", k, mem_addr[k], 9'h040 + k); end
        end
        tick();
        idle();
        @(negedge clk);
        for (int k = 0; k < PORTS; k++) begin
            total++; if (mem_addr[k] !== AW'(9'h044 + k)) begin
                bad++; $display("FAIL full_port%0d_c1: got %h want %h", k, mem_addr[k], 9'h044 + k); end
        end
        total++; if (rsp_valid !== 8'h0F) begin bad++; $display("FAIL full_rsp0: got %b want 00001111", rsp_valid); end
        for (int r = 0; r < 4; r++) begin
            total++; if (rsp_data[r] !== init_val(9'h040 + r)) begin
                bad++; $display("FAIL full_data_r%0d: got %h want %h", r, rsp_data[r], init_val(9'h040 + r)); end
        end
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 8'hF0) begin bad++; $display("FAIL full_rsp1: got %b want 11110000", rsp_valid); end
        for (int r = 4; r < REQS; r++) begin
            total++; if (rsp_data[r] !== init_val(9'h040 + r)) begin
                bad++; $display("FAIL full_data_r%0d: got %h want %h", r, rsp_data[r], init_val(9'h040 + r)); end
        end
    endtask

    task automatic test_write_collision();
        do_reset();
        set_wr(1, 9'h010, 32'hA);
        set_wr(2, 9'h010, 32'hB);
        @(negedge clk);
        total++; if (req_ready !== 8'h02) begin bad++; $display("FAIL wcol_c0: got %b want 00000010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 8'h04) begin bad++; $display("FAIL wcol_c1: got %b want 00000100", req_ready); end
        total++; if (mem_en !== 4'b0001 || mem_addr[0] !== 9'h010 || mem_d[0] !== 32'hA) begin
            bad++; $display("FAIL wcol_issue0: got en=%b addr=%h d=%h want 0001/010/a", mem_en, mem_addr[0], mem_d[0]); end
        tick();
        idle();
        @(negedge clk);
        total++; if (mem_en !== 4'b0001 || mem_d[0] !== 32'hB) begin
            bad++; $display("FAIL wcol_issue1: got en=%b d=%h want 0001/b", mem_en, mem_d[0]); end
        tick();
        set_rd(0, 9'h010);
        @(negedge clk);
        total++; if (req_ready !== 8'h01) begin bad++; $display("FAIL wcol_rd_grant: got %b want 00000001", req_ready); end
        tick();
        idle();
        tick();
        @(negedge clk);
        total++; if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hB) begin
            bad++; $display("FAIL wcol_read: got vld=%b data=%h want 1/b", rsp_valid[0], rsp_data[0]); end
    endtask

    task automatic test_read_after_write();
        do_reset();
        set_wr(0, 9'h020, 32'h55);
        set_rd(3, 9'h020);
        @(negedge clk);
        total++; if (req_ready !== 8'h01) begin bad++; $display("FAIL raw_c0: got %b want 00000001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 8'h08) begin bad++; $display("FAIL raw_c1: got %b want 00001000", req_ready); end
        tick();
        idle();
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 8'h08 || rsp_data[3] !== 32'h55) begin
            bad++; $display("FAIL raw_data: got vld=%b data=%h want 00001000/55", rsp_valid, rsp_data[3]); end
    endtask

    task automatic test_shared_read();
        do_reset();
        set_wr(4, 9'h007, 32'h1234);
        @(negedge clk);
        total++; if (req_ready !== 8'h10) begin bad++; $display("FAIL shr_wr: got %b want 00010000", req_ready); end
        tick();
        idle();
        tick();
        for (int r = 0; r < 4; r++) set_rd(r, 9'h007);
        @(negedge clk);
        total++; if (req_ready !== 8'h0F) begin bad++; $display("FAIL shr_grant: got %b want 00001111", req_ready); end
        tick();
        idle();
        @(negedge clk);
        for (int k = 0; k < PORTS; k++) begin
            total++; if (mem_addr[k] !== 9'h007) begin bad++; $display("FAIL shr_port%0d: got %h want 007", k, mem_addr[k]); end
        end
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 8'h0F) begin bad++; $display("FAIL shr_rsp: got %b want 00001111", rsp_valid); end
        for (int r = 0; r < 4; r++) begin
            total++; if (rsp_data[r] !== 32'h1234) begin bad++; $display("FAIL shr_data_r%0d: got %h want 1234", r, rsp_data[r]); end
        end
    endtask

    task automatic test_rotation();
        do_reset();
        set_rd(5, 9'h050);
        set_rd(6, 9'h060);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (req_ready !== 8'h60) begin bad++; $display("FAIL rot_grant%0d: got %b want 01100000", i, req_ready); end
            if (i > 0) begin
                total++; if (mem_addr[0] !== 9'h050 || mem_addr[1] !== 9'h060) begin
                    bad++; $display("FAIL rot_ports%0d: got %h/%h want 050/060", i, mem_addr[0], mem_addr[1]); end
            end
            tick();
        end
        set_rd(7, 9'h070);
        @(negedge clk);
        total++; if (req_ready !== 8'hE0) begin bad++; $display("FAIL rot_r7: got %b want 11100000", req_ready); end
        tick();
        idle();
        @(negedge clk);
        total++; if (mem_addr[0] !== 9'h070 || mem_addr[1] !== 9'h050 || mem_addr[2] !== 9'h060) begin
            bad++; $display("FAIL rot_ptr7: got %h/%h/%h want 070/050/060", mem_addr[0], mem_addr[1], mem_addr[2]); end
    endtask

    task automatic test_back_to_back();
        logic [REQS-1:0] acc;
        int              n_acc;
        do_reset();
        n_acc = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc   = req_valid & req_ready;
            n_acc = n_acc + $countones(acc);
            tick();
            for (int r = 0; r < REQS; r++) begin
                if (!req_valid[r] || acc[r]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        req_valid[r] = 1'b1;
                        req_we[r]    = ($urandom_range(0, 2) == 0);
                        req_addr[r]  = AW'(9'h100 + $urandom_range(0, 7));
                        req_wdata[r] = $urandom;
                    end else begin
                        req_valid[r] = 1'b0;
                    end
                end
            end
        end
        @(negedge clk);
        tick();
        idle();
        repeat (4) tick();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d outstanding want 0", sb.size()); end
        total++; if (n_acc < 300) begin bad++; $display("FAIL b2b_throughput: got %0d accepts want >= 300", n_acc); end
    endtask

    initial begin
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            mem[a]    = init_val(a);
            shadow[a] = init_val(a);
        end
        test_reset();
        test_full_load();
        test_write_collision();
        test_read_after_write();
        test_shared_read();
        test_rotation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/mpm_port_scheduler.md
# mpm_port_scheduler

Request scheduler in front of the multi-ported LVT memory. It accepts single-word read/write requests from REQS independent requesters and each cycle packs up to PORTS of them onto the memory's PORTS physical ports, using rotating priority. It never issues two same-cycle accesses that collide on an address, and it routes read data back to the originating requester. It is the only block that drives the memory's addr/en/d arrays.

## Interface
Parameters:
- WIDTH, 32, data word width (matches memory)
- DEPTH, 512, words in memory; AW = $clog2(DEPTH)
- PORTS, 4, physical memory ports
- REQS, 8, requesters; REQS >= PORTS >= 2
- RD_LAT, 1, memory read latency in cycles from addr/en presented to q valid

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid[REQS]  in  1  requester r has a request
- req_we[REQS]  in  1  1 = write, 0 = read
- req_addr[REQS]  in  AW  word address
- req_wdata[REQS]  in  WIDTH  write data
- req_ready[REQS]  out  1  request accepted this cycle (combinational from req_*)
- rsp_valid[REQS]  out  1  read data for r on rsp_data[r] this cycle
- rsp_data[REQS]  out  WIDTH  read data
- mem_addr[PORTS]  out  AW  to memory addr
- mem_en[PORTS]  out  1  to memory en (write enable)
- mem_d[PORTS]  out  WIDTH  to memory d
- mem_q[PORTS]  in  WIDTH  from memory q

## Operation
- Acceptance: a request is accepted when req_valid[r] && req_ready[r]. req_ready[r] is never high while req_valid[r] is low.
- Grant scan: each cycle, scan requesters in the order rr_ptr, rr_ptr+1, … (mod REQS). Grant each valid request unless one of these holds:
  - PORTS grants have already been made.
  - It is a write, and an already-granted request this cycle targets the same address.
  - It is a read, and an already-granted write this cycle targets the same address.
- Reads to the same address as other granted reads are allowed.
- Port assignment: the k-th grant in scan order uses port k. Ports with no grant get mem_en = 0, mem_addr = 0, mem_d = 0.
- Issue register: port assignments are registered. mem_addr, mem_en and mem_d change only on the clock edge following acceptance.
- Round-robin update: if at least one grant was made, rr_ptr <= (index of last granted requester + 1) mod REQS. Otherwise rr_ptr holds.
- Read return tracking:
  - Per port, a pipeline of depth RD_LAT+1 carries {valid, requester index} for reads.
  - When a tag exits the pipeline, rsp_valid[idx] = 1 and rsp_data[idx] = mem_q[port]. This output path is combinational from mem_q.
  - Writes produce no response.
- Ordering:
  - A write accepted at cycle T is visible to reads accepted at T+1 or later.
  - A requester's reads return in acceptance order, because latency is fixed.
- Unlisted conditions: requester-side changes of req_* while not ready are legal; requests are re-evaluated every cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - rr_ptr = 0.
  - Issue registers cleared: mem_en = 0, mem_addr = 0, mem_d = 0.
  - All read-tag valids = 0, so rsp_valid = 0.
  - req_ready = 0 for every requester while rst_n is low.
- Reset mid-operation drops all in-flight reads; no rsp_valid is produced for them.
- Latency: accept at cycle T → memory access at T+1 → rsp_valid at T+1+RD_LAT (T+2 for RD_LAT = 1).
- Throughput: PORTS accesses per cycle maximum. At most one response per requester per cycle, which holds because a requester has at most one request accepted per cycle.
- Fairness: any continuously valid request is granted within ceil(REQS/PORTS)+1 cycles, provided its address is not conflicted every cycle.

## Test plan
- Reset:
  - Stimulus: assert rst_n = 0 mid-traffic with reads in flight.
  - Required response: immediately mem_en = 0 and req_ready = 0; no rsp_valid afterwards; after release the first grant starts at requester 0.
- Full load:
  - Stimulus: REQS = 8, PORTS = 4; all 8 issue reads to distinct addresses.
  - Required response: cycle 0 grants r0–r3 on ports 0–3; cycle 1 grants r4–r7; each requester sees rsp_valid two cycles after its grant with the correct data.
- Write collision:
  - Stimulus: r1 and r2 both write address 0x10 with values 0xA and 0xB; rr_ptr = 0.
  - Required response: r1 granted in cycle 0 and r2 in cycle 1; a later read of 0x10 returns 0xB.
- Read-after-write:
  - Stimulus: r0 writes 0x20 = 0x55 while r3 reads 0x20 in the same cycle.
  - Required response: r3 deferred one cycle; its response is 0x55.
- Shared read:
  - Stimulus: r0–r3 all read 0x7; memory holds 0x1234.
  - Required response: all four granted in one cycle; each gets 0x1234 at T+2.
- Rotation:
  - Stimulus: r5 and r6 continuously valid, PORTS = 4, others idle.
  - Required response: both granted every cycle; rr_ptr alternates to 7 and stays there.
